// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay-line valid/enable controller.
package delay_ctrl_pkg;

  // Control bundle: single rising-edge clock plus asynchronous active-high reset.
  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;

  // Width needed to hold an occupancy count of 0..delay.
  function automatic int count_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/delay_stage_ctrl_cell.sv
// One stage of the delay-line controller: valid flop plus advance/enable logic.
module delay_stage_ctrl_cell
  import delay_ctrl_pkg::*;
#(
  parameter bit COLLAPSE = 1'b1
) (
  input  Util_Control_T ctrl,
  input  logic          flush,
  input  logic          inc,
  input  logic          adv_next,
  output logic          valid,
  output logic          adv,
  output logic          en
);

  logic clk;
  logic rst;

  assign clk = ctrl.clock;
  assign rst = ctrl.reset;

  // A stage may advance when empty (collapse mode) or when the downstream moves;
  // in global-stall mode adv_next already carries the shared advance.
  always_comb begin
    adv = COLLAPSE ? (!valid | adv_next) : adv_next;
    en  = adv & inc & !flush & !rst;
  end

  // Valid bit follows the incoming valid on advance, clears on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= inc;
    end
  end

endmodule

// File: rtl/delay_stage_ctrl.sv
// Valid/enable sequencer for a DELAY-stage registered delay line with
// downstream backpressure and synchronous flush. Carries no data.
module delay_stage_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int DELAY    = 2,
  parameter bit COLLAPSE = 1'b1
) (
  input  Util_Control_T                        ctrl,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  input  logic                                 flush,
  output logic [DELAY-1:0]                     en,
  output logic [DELAY-1:0]                     stage_valid,
  output logic [count_width(DELAY)-1:0]        count
);

  localparam int CW = count_width(DELAY);

  logic clk;
  logic rst;
  logic acc;
  logic drn;
  logic adv_glb;

  assign clk = ctrl.clock;
  assign rst = ctrl.reset;

  // Shared advance used when all stages move together.
  assign adv_glb = !stage_valid[DELAY-1] | out_ready;

  for (genvar i = 0; i < DELAY; i++) begin : g_stage
    logic inc_b;
    logic adv_nxt_b;
    logic adv_b;
    logic valid_b;
    logic en_b;

    if (i == 0) begin : g_inc_first
      assign inc_b = acc;
    end else begin : g_inc_chain
      assign inc_b = stage_valid[i-1];
    end

    if (!COLLAPSE) begin : g_adv_global
      assign adv_nxt_b = adv_glb;
    end else if (i == DELAY - 1) begin : g_adv_last
      assign adv_nxt_b = out_ready;
    end else begin : g_adv_chain
      assign adv_nxt_b = g_stage[i+1].adv_b;
    end

    delay_stage_ctrl_cell #(
      .COLLAPSE(COLLAPSE)
    ) u_cell (
      .ctrl     (ctrl),
      .flush    (flush),
      .inc      (inc_b),
      .adv_next (adv_nxt_b),
      .valid    (valid_b),
      .adv      (adv_b),
      .en       (en_b)
    );

    assign stage_valid[i] = valid_b;
    assign en[i]          = en_b;
  end

  // Handshakes; flush and reset both block acceptance and output.
  always_comb begin
    in_ready  = g_stage[0].adv_b & !flush & !rst;
    acc       = in_valid & in_ready;
    out_valid = stage_valid[DELAY-1] & !flush;
    drn       = out_valid & out_ready;
  end

  // Occupancy count: +1 on accept, -1 on drain, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(acc) - CW'(drn);
    end
  end

endmodule

// File: doc/delay_stage_ctrl.md
Name: delay_stage_ctrl

Overview:
- Valid/enable sequencer for a DELAY-stage registered delay line in the pipelined datapath.
- Tracks a valid bit per stage and generates per-stage load enables.
- Applies downstream backpressure (ready/valid) and supports a synchronous flush.
- Sits beside the delay-line data registers. Those registers load on en[i]; the controller carries no data itself.

Parameters:
- DELAY, 2, number of stages (>= 1); must match the controlled delay line.
- COLLAPSE, 1, 1 = bubble-collapsing per-stage advance; 0 = global stall (all stages move together).

Ports:
- ctrl  input  Util_Control_T  control bundle: ctrl.clock (single clock, rising edge), ctrl.reset (asynchronous, active-high).
- in_valid  input  1  upstream offers an item this cycle.
- in_ready  output  1  controller accepts the offered item this cycle.
- out_ready  input  1  downstream accepts the last-stage item.
- out_valid  output  1  last stage holds a valid item.
- flush  input  1  discard all in-flight items.
- en  output  DELAY  per-stage load enable; en[0] loads from the input, en[i] loads from stage i-1.
- stage_valid  output  DELAY  per-stage valid bits (debug and hazard logic).
- count  output  $clog2(DELAY+1)  number of valid stages, 0..DELAY.

Behaviour:
- Reset (async, active-high):
  - valid[] = 0, count = 0.
  - While ctrl.reset is high: out_valid = 0, in_ready = 0, en = 0.
  - First edge after release: in_ready = 1 (all stages empty).
- Incoming valid per stage: inc[0] = in_valid & in_ready; inc[i] = valid[i-1] for i > 0.
- Advance, COLLAPSE=1:
  - adv[DELAY-1] = !valid[DELAY-1] | out_ready.
  - adv[i] = !valid[i] | adv[i+1].
- Advance, COLLAPSE=0: adv[i] = !valid[DELAY-1] | out_ready for all i.
- Outputs and next state:
  - in_ready = adv[0] & !flush. This is a combinational path from out_ready; that is accepted.
  - en[i] = adv[i] & inc[i] & !flush. No enable is issued for a bubble.
  - Valid update: if adv[i], valid[i] <= inc[i]; else valid[i] holds.
  - out_valid = valid[DELAY-1] & !flush.
- Latency and throughput:
  - An item accepted at edge k is visible as out_valid after edge k+DELAY-1 when unstalled.
  - With DELAY=2: accept at edge 0, out_valid high from edge 1.
  - Throughput is 1 item/cycle when out_ready is held high.
- count register:
  - count_next = count + (in_valid & in_ready) - (out_valid & out_ready).
  - Never exceeds DELAY and never goes below 0.
  - Simultaneous accept and drain leaves count unchanged.
- Full condition: all valid and out_ready=0 → in_ready=0, en=0, state holds.
- Empty condition: out_valid=0; out_ready is ignored.
- Flush (synchronous):
  - In the flush cycle: no accept, no output handshake (out_valid forced 0), en=0.
  - Next edge: valid[] = 0, count = 0.
  - flush overrides a simultaneous in_valid or out_ready.
- Reset mid-operation: immediate clear, with no dependence on the clock.
- Boundary cases:
  - DELAY=1: stage 0 is also the last stage.
  - COLLAPSE=0 with a hole: the bubble travels; it is not squeezed out.

Decomposition:
- Package delay_ctrl_pkg:
  - function count_width(DELAY) returning $clog2(DELAY+1).
  - Reuse Util_Control_T from Util/Control.
- Sub-module delay_stage_ctrl_cell: one stage's valid flop plus adv/en logic.
  - Inputs: inc, adv_next.
  - Outputs: valid, adv, en.
  - Instantiated DELAY times in a generate loop.
- Top level: count register, flush gating, in/out handshake.

Test Plan:
- DELAY=2, out_ready=1, in_valid=1 for 4 cycles after reset:
  - Response: in_ready=1 every cycle; out_valid high from 1 cycle after the first accept; 4 output handshakes; count settles at 2, then drains to 0.
- DELAY=2, out_ready=0, in_valid=1:
  - Response: 2 accepts, then in_ready=0, en=00, count=2.
  - Raise out_ready: one drain and one accept per cycle; count stays 2.
- COLLAPSE=1, stage_valid=10, out_ready=0, in_valid=1:
  - Response: in_ready=1, en=01, next stage_valid=11.
  - Repeat with COLLAPSE=0: in_ready=0, en=00, stage_valid holds.
- count=2, flush=1 with in_valid=1 and out_ready=1:
  - Response: in_ready=0, out_valid=0, en=00.
  - Next cycle: stage_valid=00, count=0.
- Assert ctrl.reset mid-stream between clock edges with count=2:
  - Response: stage_valid=00, count=0, out_valid=0 immediately.
  - After release, first accept proceeds normally.
- DELAY=1, alternating out_ready=1/0:
  - Response: single-stage handshake correct; count toggles between 0 and 1.
